debug_frame_collector: RTL and testbench
========================================

// Module: debug_frame_collector
// PURPOSE
//  Upstream data source of the MicroBlaze/MIPS debug interface: on a read request it snapshots the selected
//  MIPS debug source (register, PC, data/instr memory word or one pipeline-latch strip) and presents it
//  as a sequence of 32-bit frames, one per advance pulse, flagging the last with end-of-data (EoD).
//  All latch strips are a fixed NB_STRIP_WORDS words; shorter strips are zero-padded by the MIPS side.
// PARAMETERS
//  NB_CONTROL_FRAME  32  frame/word width
//  NB_STRIP_WORDS    8   words per latch strip (>=2)
//  N_STRIPS          8   latch strips on i_latch_bus (fetch/deco/exec/mem x data/ctrl)
// PORTS
//  i_clock           in   1    system clock
//  i_reset           in   1    synchronous, active-high reset
//  i_read_request    in   1    one-cycle request pulse from debug interface
//  i_request_select  in   6    source code, sampled with i_read_request
//  i_next            in   1    one-cycle pulse: current frame consumed, advance
//  i_reg_data        in   32   register-file debug read data (addr = i_request_select[4:0], comb.)
//  i_pc              in   32   current PC
//  i_mem_data        in   32   data/instr memory read data, valid 1 cycle after request (sync RAM)
//  i_latch_bus       in   N_STRIPS*NB_STRIP_WORDS*32  strips concatenated, strip0 word0 at LSBs
//  o_frame           out  32   current frame to interface
//  o_frame_valid     out  1    o_frame holds a valid word
//  o_eod             out  1    current frame is the last of the transfer
//  o_busy            out  1    transfer in progress (state != IDLE)
// BEHAVIOUR
//  Clock/reset: one clock, synchronous active-high reset; reset -> IDLE, all outputs 0, buffer cleared.
//  Select decode: 6'b0x_xxxx -> register[sel[4:0]] (1 word); 6'b10_0000 mem data, 6'b10_0001 mem instr
//   (1 word, from i_mem_data); 6'b10_0010 PC (1 word); 6'b10_0100..6'b10_1011 -> strip index sel[3:0]-4
//   (NB_STRIP_WORDS words); any other code -> 1 word of 32'h0.
//  FSM: IDLE, MEM_WAIT, PRESENT.
//   IDLE: on i_read_request: latch select, word_cnt<=0, word_total<=1 or NB_STRIP_WORDS.
//    mem codes -> MEM_WAIT; others -> snapshot source into buffer this cycle, -> PRESENT.
//   MEM_WAIT (1 cycle): capture i_mem_data into buffer word0, -> PRESENT.
//   PRESENT: o_frame=buffer[word_cnt], o_frame_valid=1, o_eod=(word_cnt==word_total-1).
//    i_next with not-last word: word_cnt+1, new word visible next cycle.
//    i_next on last word: -> IDLE next cycle; o_frame_valid/o_eod drop to 0, o_frame -> 0.
//  Latency: request in cycle N -> first frame valid in N+1 (reg/PC/latch/default), N+2 (mem).
//  Snapshot: whole strip captured once at request; later changes of i_latch_bus/i_pc/i_reg_data
//   do not alter an in-progress transfer.
//  i_read_request while busy: ignored (no restart, no corruption). i_next in IDLE/MEM_WAIT: ignored.
//  i_read_request and i_next same cycle in PRESENT on last word: transfer ends, request dropped.
//  word_cnt sized clog2(NB_STRIP_WORDS); never wraps (transfer ends at last word).
//  Reset mid-transfer: immediate return to IDLE, outputs 0 next cycle.
//  o_busy=1 in MEM_WAIT and PRESENT.
// TESTING
//  Reset: assert i_reset during PRESENT word 3 -> next cycle o_frame_valid=0, o_eod=0, o_busy=0, o_frame=0.
//  Register read: sel=6'h05, i_reg_data=32'hDEADBEEF -> N+1 frame DEADBEEF, valid=1, eod=1; i_next -> idle.
//  Mem read: sel=6'h20, i_mem_data=32'h1234_5678 at N+1 -> N+2 frame 12345678 with eod=1; valid=0 at N+1.
//  Strip: sel=6'h26 (strip 2), word k=32'hA000_0000+k -> 8 frames A0000000..A0000007 over 8 i_next
//   pulses, eod only on word 7; change i_latch_bus mid-transfer -> frames unchanged.
//  Protocol abuse: i_next in IDLE -> no output; i_read_request during strip transfer -> ignored, sequence intact.
//  Unknown sel=6'h3F -> one frame 32'h0 with eod=1; then new PC request (sel=6'h22) works normally.

Source files
------------

// File: rtl/debug_frame_collector.sv
// Purpose: snapshots one MIPS debug source (register, PC, memory word or latch strip) and streams it as 32-bit frames.
// Latency: request in cycle N -> first frame in N+1 (register/PC/strip/unknown code) or N+2 (memory read).
// Backpressure: a frame is held until an i_next pulse; requests while busy and i_next while not presenting are ignored.
//
// Ports:
//   i_clock, i_reset       clock and synchronous active-high reset
//   i_read_request         one-cycle request pulse, i_request_select sampled with it
//   i_request_select[5:0]  source code (register / mem data / mem instr / PC / strip index / unknown)
//   i_next                 one-cycle pulse: current frame consumed
//   i_reg_data, i_pc       combinational register-file read data and current PC
//   i_mem_data             memory read data, valid one cycle after the request
//   i_latch_bus            N_STRIPS strips of NB_STRIP_WORDS words, strip0 word0 at LSBs
//   o_frame, o_frame_valid, o_eod, o_busy   presented frame, its qualifier, last-frame flag, transfer active
module debug_frame_collector #(
  parameter int NB_CONTROL_FRAME = 32,
  parameter int NB_STRIP_WORDS   = 8,
  parameter int N_STRIPS         = 8
) (
  input  logic                                                i_clock,
  input  logic                                                i_reset,
  input  logic                                                i_read_request,
  input  logic [5:0]                                          i_request_select,
  input  logic                                                i_next,
  input  logic [NB_CONTROL_FRAME-1:0]                         i_reg_data,
  input  logic [NB_CONTROL_FRAME-1:0]                         i_pc,
  input  logic [NB_CONTROL_FRAME-1:0]                         i_mem_data,
  input  logic [N_STRIPS*NB_STRIP_WORDS*NB_CONTROL_FRAME-1:0] i_latch_bus,
  output logic [NB_CONTROL_FRAME-1:0]                         o_frame,
  output logic                                                o_frame_valid,
  output logic                                                o_eod,
  output logic                                                o_busy
);

  localparam int CW = $clog2(NB_STRIP_WORDS);
  localparam int SW = (N_STRIPS > 1) ? $clog2(N_STRIPS) : 1;
  localparam logic [CW-1:0] LAST_STRIP_IDX = CW'(NB_STRIP_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM_WAIT,
    ST_PRESENT
  } state_t;

  state_t state_q, state_d;

  logic [NB_CONTROL_FRAME-1:0] buf_q [NB_STRIP_WORDS];
  logic [CW-1:0]               word_cnt_q;
  logic [CW-1:0]               last_idx_q;

  logic load_req;
  logic mem_cap;
  logic advance;
  logic is_last;

  // Latch bus viewed as [strip][word] so the strip select is a plain array index.
  logic [NB_CONTROL_FRAME-1:0] strip_words [N_STRIPS][NB_STRIP_WORDS];

  for (genvar s = 0; s < N_STRIPS; s++) begin : g_strip
    for (genvar w = 0; w < NB_STRIP_WORDS; w++) begin : g_word
      assign strip_words[s][w] =
        i_latch_bus[(s*NB_STRIP_WORDS + w)*NB_CONTROL_FRAME +: NB_CONTROL_FRAME];
    end
  end

  // ---------------------------------------------------------------------------
  // Select decode (only meaningful in the request cycle)
  // ---------------------------------------------------------------------------
  logic          sel_is_reg;
  logic          sel_is_mem;
  logic          sel_is_pc;
  logic          sel_is_strip;
  logic [3:0]    strip_num;
  logic [SW-1:0] strip_sel;
  logic [NB_CONTROL_FRAME-1:0] single_word;

  assign sel_is_reg = ~i_request_select[5];
  assign sel_is_mem = (i_request_select == 6'h20) || (i_request_select == 6'h21);
  assign sel_is_pc  = (i_request_select == 6'h22);
  // Strip codes 0x24..0x2B map to strip 0..7; codes beyond N_STRIPS fall back to the zero word.
  assign strip_num    = i_request_select[3:0] - 4'd4;
  assign sel_is_strip = (i_request_select[5:4] == 2'b10) &&
                        (i_request_select[3:0] >= 4'd4) &&
                        (i_request_select[3:0] <= 4'd11) &&
                        (int'(strip_num) < N_STRIPS);
  assign strip_sel    = SW'(strip_num);

  always_comb begin
    single_word = '0;
    if (sel_is_reg) begin
      single_word = i_reg_data;
    end else if (sel_is_pc) begin
      single_word = i_pc;
    end
  end

  assign is_last = (word_cnt_q == last_idx_q);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    load_req      = 1'b0;
    mem_cap       = 1'b0;
    advance       = 1'b0;
    o_frame       = '0;
    o_frame_valid = 1'b0;
    o_eod         = 1'b0;
    o_busy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_read_request) begin
          load_req = 1'b1;
          state_d  = sel_is_mem ? ST_MEM_WAIT : ST_PRESENT;
        end
      end
      ST_MEM_WAIT: begin
        // Synchronous RAM output is valid now, one cycle after the request.
        o_busy  = 1'b1;
        mem_cap = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        o_busy        = 1'b1;
        o_frame_valid = 1'b1;
        o_frame       = buf_q[word_cnt_q];
        o_eod         = is_last;
        if (i_next) begin
          if (is_last) begin
            state_d = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Snapshot buffer and word counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      word_cnt_q <= '0;
      last_idx_q <= '0;
      for (int k = 0; k < NB_STRIP_WORDS; k++) begin
        buf_q[k] <= '0;
      end
    end else if (load_req) begin
      word_cnt_q <= '0;
      last_idx_q <= sel_is_strip ? LAST_STRIP_IDX : '0;
      // Whole strip is frozen here so later bus activity cannot tear the transfer.
      for (int k = 0; k < NB_STRIP_WORDS; k++) begin
        if (sel_is_strip) begin
          buf_q[k] <= strip_words[strip_sel][k];
        end else if (k == 0) begin
          buf_q[k] <= single_word;
        end else begin
          buf_q[k] <= '0;
        end
      end
    end else if (mem_cap) begin
      buf_q[0] <= i_mem_data;
    end else if (advance) begin
      word_cnt_q <= word_cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_debug_frame_collector.sv
// Purpose: self-checking bench for debug_frame_collector against a queue-based reference model.
// Latency: expects first frame at N+1 (N+2 for memory codes) after a request in cycle N.
// Backpressure: drives i_next pulses with random gaps and stray requests while busy.
module tb_debug_frame_collector;

  localparam int LW = 8 * 8 * 32;

  logic          i_clock;
  logic          i_reset;
  logic          i_read_request;
  logic [5:0]    i_request_select;
  logic          i_next;
  logic [31:0]   i_reg_data;
  logic [31:0]   i_pc;
  logic [31:0]   i_mem_data;
  logic [LW-1:0] i_latch_bus;
  logic [31:0]   o_frame;
  logic          o_frame_valid;
  logic          o_eod;
  logic          o_busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  debug_frame_collector #(
    .NB_CONTROL_FRAME(32),
    .NB_STRIP_WORDS  (8),
    .N_STRIPS        (8)
  ) dut (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_read_request  (i_read_request),
    .i_request_select(i_request_select),
    .i_next          (i_next),
    .i_reg_data      (i_reg_data),
    .i_pc            (i_pc),
    .i_mem_data      (i_mem_data),
    .i_latch_bus     (i_latch_bus),
    .o_frame         (o_frame),
    .o_frame_valid   (o_frame_valid),
    .o_eod           (o_eod),
    .o_busy          (o_busy)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic bit is_mem(input logic [5:0] sel);
    return (sel == 6'h20) || (sel == 6'h21);
  endfunction

  function automatic logic [31:0] latch_word(input int s, input int k);
    logic [LW-1:0] t;
    t = i_latch_bus >> ((s * 8 + k) * 32);
    return t[31:0];
  endfunction

  task automatic set_latch_word(input int s, input int k, input logic [31:0] v);
    logic [LW-1:0] m;
    logic [LW-1:0] d;
    int sh;
    sh = (s * 8 + k) * 32;
    m = {{(LW-32){1'b0}}, 32'hFFFF_FFFF} << sh;
    d = {{(LW-32){1'b0}}, v} << sh;
    i_latch_bus = (i_latch_bus & ~m) | d;
  endtask

  task automatic scramble();
    for (int w = 0; w < 64; w++) begin
      i_latch_bus = {i_latch_bus[LW-33:0], 32'($urandom())};
    end
    i_pc       = $urandom();
    i_reg_data = $urandom();
    i_mem_data = $urandom();
  endtask

  // Reference model: the list of words a request should produce, taken from the
  // sources as they stand in the request cycle.
  task automatic build_exp(input logic [5:0] sel, input logic [31:0] memv);
    exp_q.delete();
    if (sel < 6'h20) begin
      exp_q.push_back(i_reg_data);
    end else if (is_mem(sel)) begin
      exp_q.push_back(memv);
    end else if (sel == 6'h22) begin
      exp_q.push_back(i_pc);
    end else if (sel >= 6'h24 && sel <= 6'h2B) begin
      for (int k = 0; k < 8; k++) begin
        exp_q.push_back(latch_word(int'(sel) - 36, k));
      end
    end else begin
      exp_q.push_back(32'h0);
    end
  endtask

  // Runs one transfer. abuse: stray requests alongside every i_next.
  // reset_at >= 0: reset is applied while that word is presented.
  task automatic do_transfer(input string tag, input logic [5:0] sel, input logic [31:0] memv,
                             input bit abuse, input int reset_at);
    int n;
    bit done;
    done = 1'b0;
    i_read_request   = 1'b1;
    i_request_select = sel;
    build_exp(sel, memv);
    tick();
    i_read_request = 1'b0;
    if (is_mem(sel)) begin
      i_mem_data = memv;
      @(negedge i_clock);
      chk({tag, " memwait valid"}, 32'(o_frame_valid), 32'd0);
      chk({tag, " memwait busy"}, 32'(o_busy), 32'd1);
      tick();
      i_mem_data = $urandom();
    end
    n = exp_q.size();
    for (int i = 0; i < n && !done; i++) begin
      repeat ($urandom_range(0, 1)) begin
        @(negedge i_clock);
        chk({tag, " hold frame"}, o_frame, exp_q[i]);
        tick();
        scramble();
      end
      @(negedge i_clock);
      chk($sformatf("%s frame%0d", tag, i), o_frame, exp_q[i]);
      chk($sformatf("%s valid%0d", tag, i), 32'(o_frame_valid), 32'd1);
      chk($sformatf("%s eod%0d", tag, i), 32'(o_eod), 32'(i == n - 1));
      chk($sformatf("%s busy%0d", tag, i), 32'(o_busy), 32'd1);
      if (i == reset_at) begin
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        done = 1'b1;
      end else begin
        i_next = 1'b1;
        if (abuse) begin
          i_read_request   = 1'b1;
          i_request_select = 6'($urandom());
        end
        tick();
        i_next         = 1'b0;
        i_read_request = 1'b0;
        scramble();
      end
    end
    @(negedge i_clock);
    chk({tag, " end valid"}, 32'(o_frame_valid), 32'd0);
    chk({tag, " end eod"}, 32'(o_eod), 32'd0);
    chk({tag, " end frame"}, o_frame, 32'd0);
    chk({tag, " end busy"}, 32'(o_busy), 32'd0);
    tick();
  endtask

  initial begin
    i_reset          = 1'b1;
    i_read_request   = 1'b0;
    i_request_select = '0;
    i_next           = 1'b0;
    i_reg_data       = '0;
    i_pc             = '0;
    i_mem_data       = '0;
    i_latch_bus      = '0;
    repeat (3) tick();
    @(negedge i_clock);
    chk("reset valid", 32'(o_frame_valid), 32'd0);
    chk("reset eod", 32'(o_eod), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset frame", o_frame, 32'd0);
    i_reset = 1'b0;
    tick();
    scramble();

    // Register read
    i_reg_data = 32'hDEAD_BEEF;
    do_transfer("reg05", 6'h05, 32'h0, 1'b0, -1);

    // Memory read: data arrives one cycle after the request
    do_transfer("mem20", 6'h20, 32'h1234_5678, 1'b0, -1);

    // Strip 2 with a known pattern, bus churned and stray requests during the transfer
    for (int k = 0; k < 8; k++) begin
      set_latch_word(2, k, 32'hA000_0000 + 32'(k));
    end
    do_transfer("strip26", 6'h26, 32'h0, 1'b1, -1);

    // i_next while idle must not start anything
    i_next = 1'b1;
    tick();
    i_next = 1'b0;
    @(negedge i_clock);
    chk("idle next valid", 32'(o_frame_valid), 32'd0);
    chk("idle next busy", 32'(o_busy), 32'd0);
    chk("idle next frame", o_frame, 32'd0);
    tick();

    // Unknown code, then a PC read
    do_transfer("unk3f", 6'h3F, 32'h0, 1'b0, -1);
    i_pc = 32'h0040_1234;
    do_transfer("pc22", 6'h22, 32'h0, 1'b0, -1);

    // Reset while presenting word 3 of a strip
    do_transfer("rst_mid", 6'h29, 32'h0, 1'b0, 3);

    // Randomized transfers over the whole code space
    for (int t = 0; t < 40; t++) begin
      scramble();
      do_transfer($sformatf("rnd%0d", t), 6'($urandom()), $urandom(),
                  1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
